config_loader: RTL and testbench
================================

# config_loader

Streaming configuration writer for the CGRA fabric. It accepts a valid/ready word stream of framed configuration records, assembles them into a shadow image, and atomically commits the image onto the `ConfigBits` inputs of the ALU, const, reg and IO primitives. Primitives only ever see a complete frame, never a partially written one.

## Interface
- `WIDTH`, 32: input word width; must be ≥ 24.
- `NUM_UNITS`, 4: number of primitives driven, 1..256.
- `CFG_BITS`, 4: config bits per primitive (NoConfigBits+1), 1..8.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: loader enable; when low, `in_ready`=0 and no word is accepted.
- `in_valid` input 1: upstream word valid.
- `in_ready` output 1: loader can accept a word.
- `in_data` input WIDTH: header or payload word.
- `cfg_bus` output NUM_UNITS*CFG_BITS: committed config; unit u occupies bits [u*CFG_BITS +: CFG_BITS].
- `cfg_update` output 1: one-cycle pulse on each commit.
- `busy` output 1: high whenever state ≠ IDLE.
- `error` output 1: sticky protocol-error flag.

## Operation
- Transfer: a word is accepted on a rising edge where `in_valid` & `in_ready` are both high. `in_ready` = `en` & (state ≠ COMMIT), combinational from registered state. `in_valid` low never changes state.
- Header word: `in_data[WIDTH-1:WIDTH-8]`=8'hA5 marks a header; `in_data[7:0]`=N gives the payload word count.
- Payload word: `in_data[15:8]` = unit address; `in_data[CFG_BITS-1:0]` = value; all other bits are ignored.
- FSM states:
  - IDLE: waiting for a header.
    - Valid header with 1 ≤ N ≤ 255: load shadow ← `cfg_bus`, remaining ← N, clear `error`, go to LOAD.
    - Any other accepted word (bad sync, or N=0): set `error`, discard the word, stay in IDLE.
  - LOAD: each accepted payload word decrements remaining.
    - Address < NUM_UNITS: shadow[addr] ← value.
    - Address ≥ NUM_UNITS: set `error`, leave shadow unchanged; the word still counts toward N.
    - Payload words are not checked for the A5 sync byte.
    - When the word with remaining=1 is accepted, go to COMMIT.
  - COMMIT: one cycle. `cfg_bus` ← shadow, `cfg_update` ← 1, go to IDLE.
- Units not addressed in a frame keep their previous value. A unit written twice in one frame takes the last value.
- `en` low during LOAD pauses the frame; the frame is never aborted. `en` has no effect on COMMIT.

## Timing
- Reset values: `cfg_bus`=0, `cfg_update`=0, `busy`=0, `error`=0, state=IDLE, shadow=0, remaining=0. `in_ready` after reset equals `en`.
- Reset mid-frame: partial frame and shadow are discarded, `cfg_bus` returns to 0 immediately (asynchronously), no `cfg_update` pulse.
- Commit latency: last payload accepted at edge k → `cfg_bus` and `cfg_update` change at edge k+1; `cfg_update` clears at edge k+2.
- `in_ready` is low for exactly the one COMMIT cycle. The next header can be accepted at edge k+2, so back-to-back frames run with one bubble cycle.
- `busy` rises at the edge that accepts the header and falls at the COMMIT edge (k+1).
- `error` sets at the edge that accepts the offending word. It holds through later commits and clears only at the next valid header accept.
- `cfg_bus` is stable between commits; it only changes at a COMMIT edge or on reset.

## Test plan
- Basic frame (WIDTH=32, NUM_UNITS=4, CFG_BITS=4): send header 0xA5000002, then payloads 0x00000103 and 0x00000305 → `cfg_update` pulses exactly once, one cycle after the last payload; `cfg_bus`=16'h5030; `error`=0.
- Partial retention: after the basic frame, send header N=1 and payload 0x0000000F → `cfg_bus`=16'h503F.
- Errors:
  - Word 0x12000001 while IDLE → `error`=1, state stays IDLE, no commit.
  - Header N=2 with payloads addr 7 (val 1) and addr 2 (val 6) → commit occurs, `cfg_bus[11:8]`=6, `error` remains 1 until the next valid header, then 0.
- Handshake: random `in_valid` gaps plus `en` dropped for 3 cycles mid-LOAD → same final `cfg_bus` as the gap-free run. Check `in_ready`=0 in the COMMIT cycle and whenever `en`=0.
- Back-to-back frames: header1, payload, header2, payload with `in_valid` held high → header2 is accepted exactly 2 edges after the last payload of frame 1; two `cfg_update` pulses, one cycle each.
- Reset mid-frame: assert `rst_n`=0 between payload 1 and payload 2 of an N=3 frame → all outputs reset immediately and there is no `cfg_update` pulse. After release, a fresh frame loads correctly from an all-zero base.

Source files
------------

// File: rtl/config_loader.sv
// Streaming configuration loader: assembles framed records into a shadow image
// and commits the whole image onto the primitive config bus in a single cycle.
module config_loader #(
    parameter int WIDTH     = 32,
    parameter int NUM_UNITS = 4,
    parameter int CFG_BITS  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic [NUM_UNITS*CFG_BITS-1:0] cfg_bus,
    output logic                          cfg_update,
    output logic                          busy,
    output logic                          error
);

    localparam int BUS_W = NUM_UNITS * CFG_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e             state_q;
    logic [BUS_W-1:0]   shadow_q;
    logic [BUS_W-1:0]   shadow_d;
    logic [7:0]         remaining_q;
    logic [BUS_W-1:0]   cfg_bus_q;
    logic               cfg_update_q;
    logic               busy_q;
    logic               error_q;

    logic               accept_s;
    logic               hdr_ok_s;
    logic [7:0]         addr_s;
    logic               addr_ok_s;
    logic [CFG_BITS-1:0] val_s;

    assign in_ready  = en & (state_q != ST_COMMIT);
    assign accept_s  = in_valid & in_ready;
    assign hdr_ok_s  = (in_data[WIDTH-1 -: 8] == 8'hA5) && (in_data[7:0] != 8'd0);
    assign addr_s    = in_data[15:8];
    assign addr_ok_s = ({1'b0, addr_s} < 9'(NUM_UNITS));
    assign val_s     = in_data[CFG_BITS-1:0];

    assign cfg_bus    = cfg_bus_q;
    assign cfg_update = cfg_update_q;
    assign busy       = busy_q;
    assign error      = error_q;

    // Shadow image with the current payload word applied to its addressed unit
    always_comb begin
        shadow_d = shadow_q;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (addr_s == 8'(u)) begin
                shadow_d[u*CFG_BITS +: CFG_BITS] = val_s;
            end else begin
                shadow_d[u*CFG_BITS +: CFG_BITS] = shadow_q[u*CFG_BITS +: CFG_BITS];
            end
        end
    end

    // Frame FSM with registered outputs; the shadow is seeded from the live bus
    // so units not addressed in a frame keep their value across the commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            remaining_q  <= 8'd0;
            cfg_bus_q    <= '0;
            cfg_update_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            cfg_update_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (hdr_ok_s) begin
                            shadow_q    <= cfg_bus_q;
                            remaining_q <= in_data[7:0];
                            error_q     <= 1'b0;
                            busy_q      <= 1'b1;
                            state_q     <= ST_LOAD;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        remaining_q <= remaining_q - 8'd1;
                        if (addr_ok_s) begin
                            shadow_q <= shadow_d;
                        end else begin
                            error_q <= 1'b1;
                        end
                        if (remaining_q == 8'd1) begin
                            state_q <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    cfg_bus_q    <= shadow_q;
                    cfg_update_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: a vector table for single-cycle behaviour
// plus hand-written sequences for handshake stalls, back-to-back frames and reset.
module tb_config_loader;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [15:0] cfg_bus;
    logic        cfg_update;
    logic        busy;
    logic        error;

    int n_vec;
    int n_bad;
    int cyc;
    int upd_cnt;
    int dbl_cnt;
    logic prev_upd;

    config_loader #(.WIDTH(32), .NUM_UNITS(4), .CFG_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .cfg_bus(cfg_bus),
        .cfg_update(cfg_update), .busy(busy), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Count cfg_update pulses and any pulse lasting more than one cycle
    always @(negedge clk) begin
        prev_upd <= cfg_update;
        if (cfg_update) upd_cnt <= upd_cnt + 1;
        if (cfg_update && prev_upd) dbl_cnt <= dbl_cnt + 1;
    end

    typedef struct {
        logic        en;
        logic        vld;
        logic [31:0] data;
        logic        rdy;
        logic [15:0] bus;
        logic        upd;
        logic        busy;
        logic        err;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Hold in_valid with word w until accepted; returns the accepting edge number
    task automatic xfer(input logic [31:0] w, output int edge_no);
        logic r;
        bit   done;
        done     = 1'b0;
        edge_no  = -1;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 20 && !done; t++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                done    = 1'b1;
                edge_no = cyc;
            end
        end
        if (!done) chk("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        in_valid = 1'b0;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e0, e1, e2, e3, u0;
        n_vec = 0; n_bad = 0; cyc = 0; upd_cnt = 0; dbl_cnt = 0; prev_upd = 1'b0;
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b0; in_data = 32'd0;

        //               en    vld   data          rdy   bus      upd   busy  err
        tbl[0]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 32'hA5000002, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 32'h00000103, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 32'h00000305, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 32'h00000000, 1'b0, 16'h5030, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 32'h00000000, 1'b1, 16'h5030, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'hA5000001, 1'b1, 16'h5030, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 32'h0000000F, 1'b1, 16'h5030, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 32'h00000000, 1'b0, 16'h503F, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 32'h12000001, 1'b1, 16'h503F, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 16'h503F, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 32'hA5000002, 1'b1, 16'h503F, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 32'h00000701, 1'b1, 16'h503F, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 32'h00000206, 1'b1, 16'h503F, 1'b0, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 16'h563F, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 16'h563F, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 32'hA5000001, 1'b1, 16'h563F, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 32'hA5000009, 1'b1, 16'h563F, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 32'h00000000, 1'b0, 16'h5639, 1'b1, 1'b0, 1'b0};
        tbl[19] = '{1'b1, 1'b1, 32'hA5000000, 1'b1, 16'h5639, 1'b0, 1'b0, 1'b1};
        tbl[20] = '{1'b1, 1'b0, 32'h00000000, 1'b1, 16'h5639, 1'b0, 1'b0, 1'b1};
        tbl[21] = '{1'b0, 1'b1, 32'hA5000001, 1'b0, 16'h5639, 1'b0, 1'b0, 1'b1};

        #2;
        chk("rst.cfg_bus", {16'd0, cfg_bus}, 32'h0);
        chk("rst.cfg_update", {31'd0, cfg_update}, 32'd0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.error", {31'd0, error}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            en = tbl[i].en; in_valid = tbl[i].vld; in_data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.cfg_bus", i), {16'd0, cfg_bus}, {16'd0, tbl[i].bus});
            chk($sformatf("v%0d.cfg_update", i), {31'd0, cfg_update}, {31'd0, tbl[i].upd});
            chk($sformatf("v%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("v%0d.error", i), {31'd0, error}, {31'd0, tbl[i].err});
        end

        // Handshake: random gaps plus en dropped for 3 cycles mid-frame
        en = 1'b1;
        idle_cycles(2);
        u0 = upd_cnt;
        xfer(32'hA5000003, e0);
        idle_cycles($urandom_range(0, 3));
        xfer(32'h00000101, e0);
        en = 1'b0; in_valid = 1'b1; in_data = 32'h00000202;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("hs.ready_en_low", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("hs.busy_paused", {31'd0, busy}, 32'd1);
        chk("hs.bus_paused", {16'd0, cfg_bus}, 32'h5639);
        en = 1'b1;
        xfer(32'h00000202, e0);
        idle_cycles($urandom_range(0, 3));
        xfer(32'h00000304, e0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("hs.ready_commit", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("hs.update", {31'd0, cfg_update}, 32'd1);
        chk("hs.cfg_bus", {16'd0, cfg_bus}, 32'h4219);
        chk("hs.error", {31'd0, error}, 32'd0);
        idle_cycles(2);
        chk("hs.pulses", upd_cnt - u0, 32'd1);

        // Back-to-back frames with in_valid held high
        u0 = upd_cnt;
        xfer(32'hA5000001, e0);
        xfer(32'h00000107, e1);
        xfer(32'hA5000001, e2);
        xfer(32'h00000208, e3);
        in_valid = 1'b0;
        idle_cycles(3);
        chk("b2b.hdr2_gap", e2 - e1, 32'd2);
        chk("b2b.pulses", upd_cnt - u0, 32'd2);
        chk("b2b.long_pulse", dbl_cnt, 32'd0);
        chk("b2b.cfg_bus", {16'd0, cfg_bus}, 32'h4879);

        // Reset mid-frame: outputs clear asynchronously, no commit pulse
        u0 = upd_cnt;
        xfer(32'hA5000003, e0);
        xfer(32'h00000103, e0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.cfg_bus", {16'd0, cfg_bus}, 32'h0);
        chk("mrst.busy", {31'd0, busy}, 32'd0);
        chk("mrst.error", {31'd0, error}, 32'd0);
        chk("mrst.update", {31'd0, cfg_update}, 32'd0);
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
        chk("mrst.no_pulse", upd_cnt - u0, 32'd0);
        xfer(32'hA5000001, e0);
        xfer(32'h00000302, e0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst.fresh_update", {31'd0, cfg_update}, 32'd1);
        chk("mrst.fresh_bus", {16'd0, cfg_bus}, 32'h2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
